// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the Smith-Waterman tile scheduler:
//   - CELL_W / TILE / SEG_W / BND_W : cell width, tile side, sequence segment
//     width and boundary vector width.
//   - state_e                      : scheduler FSM states.
//   - cell_at(vec, i)              : extract cell i from a packed boundary vector.
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int CELL_W = 8;
  localparam int TILE   = 16;
  localparam int SEG_W  = 32;
  localparam int BND_W  = TILE * CELL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_e;

  function automatic logic [CELL_W-1:0] cell_at(input logic [BND_W-1:0] vec,
                                                 input int              i);
    return vec[i*CELL_W +: CELL_W];
  endfunction

endpackage

// File: rtl/sw_boundary_buf.sv
// -----------------------------------------------------------------------------
// sw_boundary_buf
// Holds the bottom row of the most recent tile in each tile column, i.e. the
// top boundary for the next tile row.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (clears all rows)
//   clr              : synchronous clear of every row (new alignment)
//   rd_idx / rd_data : combinational read of one row
//   wr_en / wr_idx / wr_data : row write on the next clock edge
//   old_top          : last cell (cell TILE-1) of the row at wr_idx as it is
//                      before the write; becomes the next tile's corner cell
// -----------------------------------------------------------------------------
module sw_boundary_buf
  import sw_pkg::*;
#(
  parameter int TPS = 4,
  parameter int IW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [IW-1:0]     rd_idx,
  output logic [BND_W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [BND_W-1:0]  wr_data,
  output logic [CELL_W-1:0] old_top
);

  logic [BND_W-1:0] mem_q [TPS];
  logic [BND_W-1:0] mem_d [TPS];

  always_comb begin
    for (int i = 0; i < TPS; i++) begin
      mem_d[i] = clr ? '0 : mem_q[i];
    end
    if (!clr && wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];
  // Read from the registered copy so the value is the pre-write contents.
  assign old_top = cell_at(mem_q[wr_idx], TILE - 1);

endmodule

// File: rtl/sw_tile_scheduler.sv
// -----------------------------------------------------------------------------
// sw_tile_scheduler
// Walks a TPS x TPS grid of 16x16 Smith-Waterman tiles in row-major order,
// issuing operands to one tile solver and folding its results back in.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, seq_a, seq_b   : begin alignment, sequences latched on accepted start
//   tile_start, tile_num  : issue pulse and index r*TPS+c of the issued tile
//   s1_seg, s2_seg        : sequence segments for tile column c / tile row r
//   first_row, first_col, diag_cell : top, left and corner boundary operands
//   tile_valid, last_row, last_col, tile_max, tile_max_row, tile_max_col :
//                           solver result for the outstanding tile
//   busy, done            : run status, done is a one-cycle pulse
//   max_value, max_row, max_col : global maximum score and its cell position
// -----------------------------------------------------------------------------
module sw_tile_scheduler #(
  parameter int TPS    = 4,
  parameter int CELL_W = 8,
  parameter int TILE   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [TPS*32-1:0]             seq_a,
  input  logic [TPS*32-1:0]             seq_b,
  output logic                          tile_start,
  output logic [3:0]                    tile_num,
  output logic [31:0]                   s1_seg,
  output logic [31:0]                   s2_seg,
  output logic [TILE*CELL_W-1:0]        first_row,
  output logic [TILE*CELL_W-1:0]        first_col,
  output logic [CELL_W-1:0]             diag_cell,
  input  logic                          tile_valid,
  input  logic [TILE*CELL_W-1:0]        last_row,
  input  logic [TILE*CELL_W-1:0]        last_col,
  input  logic [CELL_W-1:0]             tile_max,
  input  logic [3:0]                    tile_max_row,
  input  logic [3:0]                    tile_max_col,
  output logic                          busy,
  output logic                          done,
  output logic [CELL_W-1:0]             max_value,
  output logic [$clog2(TPS*TILE)-1:0]   max_row,
  output logic [$clog2(TPS*TILE)-1:0]   max_col
);

  import sw_pkg::*;

  localparam int CW = (TPS > 1) ? $clog2(TPS) : 1;
  localparam int MW = $clog2(TPS * TILE);
  localparam int VW = TILE * CELL_W;

  state_e               state_q, state_d;
  logic [CW-1:0]        r_q, r_d, c_q, c_d;
  logic [TPS*SEG_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [VW-1:0]        col_q, col_d;
  logic [CELL_W-1:0]    diag_q, diag_d;
  logic [VW-1:0]        res_row_q, res_row_d, res_col_q, res_col_d;
  logic [CELL_W-1:0]    res_max_q, res_max_d;
  logic [3:0]           res_mr_q, res_mr_d, res_mc_q, res_mc_d;
  logic [CELL_W-1:0]    max_val_q, max_val_d;
  logic [MW-1:0]        max_row_q, max_row_d, max_col_q, max_col_d;

  logic                 buf_clr, buf_wr;
  logic [VW-1:0]        buf_rd;
  logic [CELL_W-1:0]    buf_top;
  logic                 last_tile;

  sw_boundary_buf #(
    .TPS (TPS),
    .IW  (CW)
  ) u_rowbuf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .rd_idx  (c_q),
    .rd_data (buf_rd),
    .wr_en   (buf_wr),
    .wr_idx  (c_q),
    .wr_data (res_row_q),
    .old_top (buf_top)
  );

  assign last_tile = (r_q == CW'(TPS - 1)) && (c_q == CW'(TPS - 1));

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    col_d      = col_q;
    diag_d     = diag_q;
    res_row_d  = res_row_q;
    res_col_d  = res_col_q;
    res_max_d  = res_max_q;
    res_mr_d   = res_mr_q;
    res_mc_d   = res_mc_q;
    max_val_d  = max_val_q;
    max_row_d  = max_row_q;
    max_col_d  = max_col_q;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    tile_start = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d      = seq_a;
          sb_d      = seq_b;
          r_d       = '0;
          c_d       = '0;
          col_d     = '0;
          diag_d    = '0;
          max_val_d = '0;
          max_row_d = '0;
          max_col_d = '0;
          buf_clr   = 1'b1;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        tile_start = 1'b1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (tile_valid) begin
          res_row_d = last_row;
          res_col_d = last_col;
          res_max_d = tile_max;
          res_mr_d  = tile_max_row;
          res_mc_d  = tile_max_col;
          state_d   = S_UPDATE;
        end
      end

      S_UPDATE: begin
        buf_wr = 1'b1;
        // Moving right: the old bottom-right cell of the tile above the
        // just-finished one is the corner for the next tile in this row.
        if (c_q < CW'(TPS - 1)) begin
          c_d    = c_q + CW'(1);
          col_d  = res_col_q;
          diag_d = buf_top;
        end else begin
          c_d    = '0;
          r_d    = r_q + CW'(1);
          col_d  = '0;
          diag_d = '0;
        end
        // Strict compare: on a tie the earlier tile's position is kept.
        if (res_max_q > max_val_q) begin
          max_val_d = res_max_q;
          max_row_d = MW'(int'(r_q) * TILE + int'(res_mr_q));
          max_col_d = MW'(int'(c_q) * TILE + int'(res_mc_q));
        end
        state_d = last_tile ? S_DONE : S_ISSUE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      col_q     <= '0;
      diag_q    <= '0;
      res_row_q <= '0;
      res_col_q <= '0;
      res_max_q <= '0;
      res_mr_q  <= '0;
      res_mc_q  <= '0;
      max_val_q <= '0;
      max_row_q <= '0;
      max_col_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      col_q     <= col_d;
      diag_q    <= diag_d;
      res_row_q <= res_row_d;
      res_col_q <= res_col_d;
      res_max_q <= res_max_d;
      res_mr_q  <= res_mr_d;
      res_mc_q  <= res_mc_d;
      max_val_q <= max_val_d;
      max_row_q <= max_row_d;
      max_col_q <= max_col_d;
    end
  end

  assign tile_num  = 4'(int'(r_q) * TPS + int'(c_q));
  assign s1_seg    = sa_q[c_q*SEG_W +: SEG_W];
  assign s2_seg    = sb_q[r_q*SEG_W +: SEG_W];
  assign first_row = buf_rd;
  assign first_col = col_q;
  assign diag_cell = diag_q;
  assign busy      = (state_q != S_IDLE);
  assign max_value = max_val_q;
  assign max_row   = max_row_q;
  assign max_col   = max_col_q;

endmodule

// File: tb/tb_sw_tile_scheduler.sv
`timescale 1ns/1ps
module tb_sw_tile_scheduler;

  localparam int TPS = 4;
  localparam int MW  = $clog2(TPS*16);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [TPS*32-1:0] seq_a, seq_b;
  logic              tile_start;
  logic [3:0]        tile_num;
  logic [31:0]       s1_seg, s2_seg;
  logic [127:0]      first_row, first_col;
  logic [7:0]        diag_cell;
  logic              tile_valid;
  logic [127:0]      last_row, last_col;
  logic [7:0]        tile_max;
  logic [3:0]        tile_max_row, tile_max_col;
  logic              busy, done;
  logic [7:0]        max_value;
  logic [MW-1:0]     max_row, max_col;

  sw_tile_scheduler #(.TPS(TPS), .CELL_W(8), .TILE(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seq_a(seq_a), .seq_b(seq_b),
    .tile_start(tile_start), .tile_num(tile_num), .s1_seg(s1_seg), .s2_seg(s2_seg),
    .first_row(first_row), .first_col(first_col), .diag_cell(diag_cell),
    .tile_valid(tile_valid), .last_row(last_row), .last_col(last_col),
    .tile_max(tile_max), .tile_max_row(tile_max_row), .tile_max_col(tile_max_col),
    .busy(busy), .done(done), .max_value(max_value), .max_row(max_row), .max_col(max_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   tn;
    logic [31:0]  s1;
    logic [31:0]  s2;
    logic [127:0] frow;
    logic [127:0] fcol;
    logic [7:0]   diag;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [7:0]    mx_v [16];
  logic [3:0]    mx_r [16];
  logic [3:0]    mx_c [16];
  logic [7:0]    em;
  logic [MW-1:0] er, ec;

  function automatic logic [127:0] fill(input logic [7:0] v);
    logic [127:0] x;
    for (int i = 0; i < 16; i++) x[8*i +: 8] = v;
    return x;
  endfunction

  task automatic set_default_max();
    for (int t = 0; t < 16; t++) begin
      mx_v[t] = 8'(t * 5);
      mx_r[t] = 4'(t);
      mx_c[t] = 4'(15 - t);
    end
  endtask

  // Full alignment with a solver of latency lat. Expected operands for every
  // tile are queued up front and popped on each tile_start.
  task automatic run_job(input int lat, input bit inject, input bit poke, input string tag);
    exp_t e;
    int cyc, issued, due, rr, cc;
    logic [3:0] cur;
    bit fin;
    logic [TPS*32-1:0] sa, sb;
    sa = {$urandom, $urandom, $urandom, $urandom};
    sb = {$urandom, $urandom, $urandom, $urandom};
    q.delete();
    for (int t = 0; t < 16; t++) begin
      rr = t / TPS;
      cc = t % TPS;
      e.tn   = 4'(t);
      e.s1   = sa[32*cc +: 32];
      e.s2   = sb[32*rr +: 32];
      e.frow = (rr == 0) ? 128'd0 : fill(8'((rr-1)*TPS + cc));
      e.fcol = (cc == 0) ? 128'd0 : fill(8'(rr*TPS + cc - 1));
      e.diag = (rr == 0 || cc == 0) ? 8'd0 : 8'((rr-1)*TPS + cc - 1);
      q.push_back(e);
    end
    em = 8'd0; er = '0; ec = '0;
    for (int t = 0; t < 16; t++) begin
      if (mx_v[t] > em) begin
        em = mx_v[t];
        er = MW'((t / TPS) * 16 + int'(mx_r[t]));
        ec = MW'((t % TPS) * 16 + int'(mx_c[t]));
      end
    end
    seq_a = sa; seq_b = sb; start = 1'b1;
    cyc = 0; issued = 0; due = -1; cur = 4'd0; fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      tile_valid = 1'b0;
      if (poke && cyc == 4) begin
        seq_a = ~sa; seq_b = ~sb; start = 1'b1;
      end
      if (cyc == 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_running: got %b want 1", tag, busy); end
      end
      if (tile_start) begin
        issued++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL %s extra_tile: got tile %0d want none", tag, tile_num);
        end else begin
          e = q.pop_front();
          checks++;
          if (tile_num !== e.tn) begin errors++; $display("FAIL %s tile_num: got %0d want %0d", tag, tile_num, e.tn); end
          checks++;
          if (s1_seg !== e.s1 || s2_seg !== e.s2) begin errors++; $display("FAIL %s segs tile %0d: got %h/%h want %h/%h", tag, e.tn, s1_seg, s2_seg, e.s1, e.s2); end
          checks++;
          if (first_row !== e.frow) begin errors++; $display("FAIL %s first_row tile %0d: got %h want %h", tag, e.tn, first_row, e.frow); end
          checks++;
          if (first_col !== e.fcol) begin errors++; $display("FAIL %s first_col tile %0d: got %h want %h", tag, e.tn, first_col, e.fcol); end
          checks++;
          if (diag_cell !== e.diag) begin errors++; $display("FAIL %s diag_cell tile %0d: got %0d want %0d", tag, e.tn, diag_cell, e.diag); end
        end
        cur = tile_num;
        due = cyc + lat;
        if (inject && tile_num == 4'd3) begin
          tile_valid = 1'b1; last_row = '1; last_col = '1;
          tile_max = 8'hff; tile_max_row = 4'hf; tile_max_col = 4'hf;
        end
      end else if (cyc == due) begin
        tile_valid   = 1'b1;
        last_row     = fill(8'(cur));
        last_col     = fill(8'(cur));
        tile_max     = mx_v[cur];
        tile_max_row = mx_r[cur];
        tile_max_col = mx_c[cur];
      end
      if (done) begin
        fin = 1'b1;
        checks++;
        if (cyc != 16*(2+lat) + 1) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, cyc, 16*(2+lat)+1); end
      end else if (cyc > 16*(2+lat) + 50) begin
        fin = 1'b1;
        checks++; errors++;
        $display("FAIL %s done_timeout: got no done after %0d cycles want %0d", tag, cyc, 16*(2+lat)+1);
      end
    end
    checks++;
    if (issued != 16) begin errors++; $display("FAIL %s tile_count: got %0d want 16", tag, issued); end
    checks++;
    if (max_value !== em) begin errors++; $display("FAIL %s max_value: got %0d want %0d", tag, max_value, em); end
    checks++;
    if (max_row !== er || max_col !== ec) begin errors++; $display("FAIL %s max_pos: got (%0d,%0d) want (%0d,%0d)", tag, max_row, max_col, er, ec); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s idle_after: got busy=%b done=%b want 0/0", tag, busy, done); end
    checks++;
    if (max_value !== em) begin errors++; $display("FAIL %s max_hold: got %0d want %0d", tag, max_value, em); end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tile_start !== 1'b0 || tile_num !== 4'd0)
      begin errors++; $display("FAIL reset_ctrl: got busy=%b done=%b ts=%b tn=%0d want 0", busy, done, tile_start, tile_num); end
    checks++;
    if (first_row !== 128'd0 || first_col !== 128'd0 || diag_cell !== 8'd0 || max_value !== 8'd0 || max_row !== '0 || max_col !== '0)
      begin errors++; $display("FAIL reset_data: got fr=%h fc=%h d=%0d mv=%0d want 0", first_row, first_col, diag_cell, max_value); end
    reset = 1'b0;
    @(posedge clk); #1;
    tile_valid = 1'b1;
    @(posedge clk); #1;
    tile_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || tile_start !== 1'b0) begin errors++; $display("FAIL idle_no_start: got busy=%b ts=%b want 0/0", busy, tile_start); end
  endtask

  task automatic test_boundaries_l1();
    set_default_max();
    run_job(1, 1'b0, 1'b0, "l1");
  endtask

  task automatic test_max_merge();
    for (int t = 0; t < 16; t++) begin
      mx_v[t] = 8'(t + 10); mx_r[t] = 4'(t); mx_c[t] = 4'(t);
    end
    mx_v[9]  = 8'd200; mx_r[9]  = 4'd3; mx_c[9]  = 4'd7;
    mx_v[14] = 8'd200; mx_r[14] = 4'd5; mx_c[14] = 4'd5;
    run_job(3, 1'b0, 1'b0, "maxmerge");
    checks++;
    if (max_value !== 8'd200 || max_row !== MW'(35) || max_col !== MW'(23))
      begin errors++; $display("FAIL max_tie: got %0d@(%0d,%0d) want 200@(35,23)", max_value, max_row, max_col); end
  endtask

  task automatic test_latency_20();
    set_default_max();
    run_job(20, 1'b0, 1'b0, "l20");
  endtask

  task automatic test_ignored_inputs();
    set_default_max();
    run_job(2, 1'b1, 1'b1, "ignored");
  endtask

  task automatic test_reset_mid_wait();
    int due;
    logic [3:0] cur;
    bit hit;
    for (int t = 0; t < 16; t++) begin
      mx_v[t] = 8'(t + 40); mx_r[t] = 4'(t); mx_c[t] = 4'(2);
    end
    seq_a = {$urandom, $urandom, $urandom, $urandom};
    seq_b = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; due = -1; hit = 1'b0; cur = 4'd0;
    for (int cyc = 1; cyc < 300 && !hit; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; tile_valid = 1'b0;
      if (tile_start) begin
        cur = tile_num; due = cyc + 3;
        if (tile_num == 4'd5) hit = 1'b1;
      end else if (cyc == due) begin
        tile_valid = 1'b1; last_row = fill(8'(cur)); last_col = fill(8'(cur));
        tile_max = mx_v[cur]; tile_max_row = mx_r[cur]; tile_max_col = mx_c[cur];
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_wait_tile5: got no tile 5 want issue"); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || max_value !== 8'd44 || max_row !== MW'(20) || max_col !== MW'(2))
      begin errors++; $display("FAIL pre_reset: got busy=%b %0d@(%0d,%0d) want 1 44@(20,2)", busy, max_value, max_row, max_col); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tile_start !== 1'b0 || tile_num !== 4'd0 || s1_seg !== 32'd0 || s2_seg !== 32'd0)
      begin errors++; $display("FAIL async_reset_ctrl: got busy=%b ts=%b tn=%0d s1=%h want 0", busy, tile_start, tile_num, s1_seg); end
    checks++;
    if (first_row !== 128'd0 || first_col !== 128'd0 || diag_cell !== 8'd0 || max_value !== 8'd0 || max_row !== '0 || max_col !== '0)
      begin errors++; $display("FAIL async_reset_data: got fc=%h mv=%0d want 0", first_col, max_value); end
    @(posedge clk); #1;
    reset = 1'b0;
    tile_valid = 1'b1;
    @(posedge clk); #1;
    tile_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || max_value !== 8'd0) begin errors++; $display("FAIL after_reset: got busy=%b mv=%0d want 0/0", busy, max_value); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 16; t++) begin
        mx_v[t] = 8'($urandom_range(0, 255));
        mx_r[t] = 4'($urandom_range(0, 15));
        mx_c[t] = 4'($urandom_range(0, 15));
      end
      run_job(1 + k, 1'b0, 1'b0, "b2b");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seq_a = '0; seq_b = '0;
    tile_valid = 1'b0; last_row = '0; last_col = '0;
    tile_max = '0; tile_max_row = '0; tile_max_col = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_boundaries_l1();
    test_max_merge();
    test_latency_20();
    test_ignored_inputs();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
